// File: rtl/user_sprite_renderer.sv
// Sprite layer: latches sprite position per frame, addresses the sprite ROM inside the box, emits RGB + opaque flag.
// Latency 3 cycles from pixel coordinate to output; 1 pixel/cycle, never stalls (no backpressure).
module user_sprite_renderer #(
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  output logic [9:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] sprite_rgb,
  output logic        sprite_on
);

  localparam int XB = $clog2(SPRITE_W);
  localparam int YB = $clog2(SPRITE_H);

  logic [9:0]    pos_x;
  logic [9:0]    pos_y;
  logic          in_box_d1;
  logic          in_box_d2;

  logic          in_box;
  logic [XB-1:0] dx;
  logic [YB-1:0] dy;
  logic [9:0]    addr_next;
  logic          on_next;
  logic [11:0]   rgb_next;

  // Shadow position only moves at frame start so a moving sprite never tears.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (frame_start) begin
      pos_x <= sprite_x;
      pos_y <= sprite_y;
    end
  end

  // 11-bit compare: pos + size cannot wrap, so a sprite near the right edge clips.
  always_comb begin
    in_box = ({1'b0, pixel_x} >= {1'b0, pos_x}) &&
             ({1'b0, pixel_x} <  ({1'b0, pos_x} + 11'(SPRITE_W))) &&
             ({1'b0, pixel_y} >= {1'b0, pos_y}) &&
             ({1'b0, pixel_y} <  ({1'b0, pos_y} + 11'(SPRITE_H))) &&
             video_on;
    dx        = pixel_x[XB-1:0] - pos_x[XB-1:0];
    dy        = pixel_y[YB-1:0] - pos_y[YB-1:0];
    addr_next = 10'({dy, dx});
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
    end else begin
      rom_addr  <= addr_next;
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
    end
  end

  always_comb begin
    on_next  = in_box_d2 && (rom_data != TRANSPARENT);
    rgb_next = on_next ? rom_data : 12'h000;
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      sprite_on  <= 1'b0;
      sprite_rgb <= '0;
    end else begin
      sprite_on  <= on_next;
      sprite_rgb <= rgb_next;
    end
  end

endmodule

// File: doc/user_sprite_renderer.md
Name: user_sprite_renderer

Overview:
- Consumer side of the `sprite_x`/`sprite_y` interface driven by the user sprite movement controller.
- Each frame it latches the sprite position and compares the VGA scan position against the sprite box.
- Inside the box it addresses the external synchronous sprite ROM and emits the sprite's 12-bit RGB pixel plus an opaque flag.
- The VGA colour mux downstream uses the opaque flag to choose between the sprite and the background layer.

Parameters:
- SPRITE_W, 32, sprite width in pixels; must be a power of two, 32 max.
- SPRITE_H, 32, sprite height in pixels; must be a power of two, 32 max.
- TRANSPARENT, 12'h000, ROM colour treated as see-through.

Ports:
- clk25  input  1  25 MHz pixel clock.
- rst  input  1  reset, asynchronous, active-high.
- frame_start  input  1  one-cycle pulse at the start of vertical blanking.
- sprite_x  input  10  sprite left edge from the movement controller.
- sprite_y  input  10  sprite top edge from the movement controller.
- pixel_x  input  10  current scan column.
- pixel_y  input  10  current scan row.
- video_on  input  1  high in the visible region.
- rom_addr  output  10  sprite ROM address, registered.
- rom_data  input  12  ROM output; valid one cycle after `rom_addr`.
- sprite_rgb  output  12  sprite colour; 0 when `sprite_on` is 0.
- sprite_on  output  1  high when this pixel is an opaque sprite pixel.

Behaviour:
- Reset (async, immediate):
  - Shadow position registers `pos_x`/`pos_y` = 0.
  - All pipeline registers = 0.
  - `rom_addr` = 0, `sprite_rgb` = 0, `sprite_on` = 0.
  - Operation restarts cleanly after deassertion. Pixels in flight are discarded; no partial output appears.
- Position latch:
  - On a `clk25` edge with `frame_start` = 1: `pos_x` <= `sprite_x`, `pos_y` <= `sprite_y`.
  - Otherwise the shadow registers hold, so mid-frame movement never tears the image.
  - A pixel sampled in the same cycle as `frame_start` uses the old `pos`.
- Stage 1 (edge ending cycle c):
  - `dx` = `pixel_x` − `pos_x`, `dy` = `pixel_y` − `pos_y`.
  - Compare in 11-bit unsigned arithmetic: `in_box` = (`pixel_x` ≥ `pos_x`) & (`pixel_x` < `pos_x`+SPRITE_W) & (`pixel_y` ≥ `pos_y`) & (`pixel_y` < `pos_y`+SPRITE_H) & `video_on`.
  - `rom_addr` <= {`dy`[log2 SPRITE_H−1:0], `dx`[log2 SPRITE_W−1:0]}, zero-extended to 10 bits.
  - `rom_addr` updates every cycle; its value is don't-care when `in_box` = 0.
  - `in_box` is registered alongside `rom_addr`.
- Stage 2 (cycle c+1):
  - The external ROM registers its data.
  - The `in_box` flag is delayed one more register to align with `rom_data`.
- Stage 3 (edge ending cycle c+2):
  - `sprite_on` <= `in_box_d2` & (`rom_data` ≠ TRANSPARENT).
  - `sprite_rgb` <= `sprite_on`-next ? `rom_data` : 0.
- Total latency: pixel presented in cycle c appears on the outputs in cycle c+3. The downstream mux delays `pixel_x`/`pixel_y`/`video_on` by 3 to match.
- Boundaries:
  - `pos_x`+SPRITE_W > 639: the sprite clips at the right edge; no wrap to column 0, because the 11-bit compare prevents overflow.
  - `pos_x` = 1023: no pixel is drawn.
  - Box edges: the right and bottom edges are exclusive (column `pos_x`+SPRITE_W is outside).
  - `video_on` = 0 inside the box: `sprite_on` = 0.
- No internal state machine beyond the 3-stage pipeline and the shadow registers. Throughput is 1 pixel/cycle with no stalls.

Test Plan:
- Reset mid-frame with the pipeline full → `sprite_on`, `sprite_rgb`, `rom_addr` read 0 immediately. After release with no `frame_start`, `pos` = (0,0).
- `sprite_x`=100, `sprite_y`=50, pulse `frame_start`, scan (100,50) → `rom_addr`=0 one cycle later; with ROM[0]=12'hF00, `sprite_on`=1 and `sprite_rgb`=12'hF00 three cycles after the pixel.
- Same position, scan (131,81) and (132,81) → `rom_addr`=1023 and `sprite_on`=1 for the first; `sprite_on`=0 and `sprite_rgb`=0 for the second.
- ROM word = 12'h000 at an in-box address → `sprite_on`=0 and `sprite_rgb`=0.
- Change `sprite_x` to 200 mid-frame without `frame_start` → the drawn box stays at x=100 until the next `frame_start` pulse, then moves to 200.
- `sprite_x`=620, `frame_start`, scan x=619..639 then x=0 → on for 620..639 only; x=0..11 off, so there is no wrap.
